// File: rtl/c_wf_alloc_iter_ctrl.sv
// Multi-pass sequencer for a combinational wavefront allocator: masks granted rows/cols per pass
// and accumulates one conflict-free matching. Optional grant check: C_WF_ALLOC_ITER_CTRL_CHECK_EN.
module c_wf_alloc_iter_ctrl #(
    parameter int num_ports = 8,
    parameter int num_iters = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           active,
    input  logic                           start,
    input  logic [num_ports*num_ports-1:0] req,
    output logic                           busy,
    output logic [num_ports*num_ports-1:0] alloc_req,
    input  logic [num_ports*num_ports-1:0] alloc_gnt,
    output logic                           alloc_update,
    output logic                           gnt_valid,
    output logic [num_ports*num_ports-1:0] gnt,
    input  logic                           ack,
    output logic                           err
);

    localparam int NN = num_ports * num_ports;
    localparam int IW = (num_iters > 1) ? $clog2(num_iters) : 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(num_iters - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [NN-1:0]  req_q;
    logic [NN-1:0]  gnt_q;
    logic [IW-1:0]  iter_q;

    logic [num_ports-1:0] row_g;
    logic [num_ports-1:0] col_g;
    logic [NN-1:0]        masked_req;
    logic [NN-1:0]        new_gnt;
    logic [NN-1:0]        new_acc;
    logic                 conflict;
    logic                 run_last;

    always_comb begin
        row_g = '0;
        col_g = '0;
        for (int unsigned r = 0; r < num_ports; r++) begin
            for (int unsigned c = 0; c < num_ports; c++) begin
                if (gnt_q[r*num_ports+c]) begin
                    row_g[r] = 1'b1;
                    col_g[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        masked_req = '0;
        for (int unsigned r = 0; r < num_ports; r++) begin
            for (int unsigned c = 0; c < num_ports; c++) begin
                masked_req[r*num_ports+c] = req_q[r*num_ports+c] & ~row_g[r] & ~col_g[c];
            end
        end
    end

    assign alloc_req = (state_q == RUN) ? masked_req : '0;
    // Only bits we actually asked for are accepted; stray allocator grants drop out here.
    assign new_gnt   = alloc_gnt & alloc_req;

`ifdef C_WF_ALLOC_ITER_CTRL_CHECK_EN
    logic [num_ports-1:0] row_seen;
    logic [num_ports-1:0] col_seen;
    logic                 err_q;

    always_comb begin
        row_seen = '0;
        col_seen = '0;
        conflict = 1'b0;
        for (int unsigned r = 0; r < num_ports; r++) begin
            for (int unsigned c = 0; c < num_ports; c++) begin
                if (new_gnt[r*num_ports+c]) begin
                    if (row_seen[r] | col_seen[c]) conflict = 1'b1;
                    row_seen[r] = 1'b1;
                    col_seen[c] = 1'b1;
                end
            end
        end
    end

    assign err = err_q;
`else
    assign conflict = 1'b0;
    assign err      = 1'b0;
`endif

    assign new_acc  = conflict ? '0 : new_gnt;
    assign run_last = (iter_q == LAST_ITER) || (new_acc == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_last) state_d = DONE;
            DONE:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign gnt_valid    = (state_q == DONE);
    assign gnt          = gnt_valid ? gnt_q : '0;
    assign alloc_update = active && (state_q == RUN) && run_last && ((gnt_q | new_acc) != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            gnt_q   <= '0;
            iter_q  <= '0;
        end else if (active) begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        req_q  <= req;
                        gnt_q  <= '0;
                        iter_q <= '0;
                    end
                end
                RUN: begin
                    gnt_q  <= gnt_q | new_acc;
                    iter_q <= iter_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef C_WF_ALLOC_ITER_CTRL_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (active && (state_q == RUN) && conflict) begin
            err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_c_wf_alloc_iter_ctrl.sv
// Directed bench for c_wf_alloc_iter_ctrl, num_ports=4, with one instance at num_iters=2
// and one at num_iters=3, each driven by a behavioural allocator model.
module tb_c_wf_alloc_iter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, active, start, ack;
    logic [15:0] req;

    logic        busy2, upd2, gv2, err2;
    logic [15:0] areq2, agnt2, gnt2;
    logic        busy3, upd3, gv3, err3;
    logic [15:0] areq3, agnt3, gnt3;

    int          mode2, mode3;
    logic [15:0] fix2, fix3;

    int tests = 0;
    int fails = 0;

    // mode 0: greedy maximal matching from highest index; 1: highest single bit; 2: fixed pattern
    function automatic logic [15:0] model(input int mode, input logic [15:0] ar, input logic [15:0] fixed);
        logic [15:0] g;
        logic [3:0]  ru, cu;
        g  = '0;
        ru = '0;
        cu = '0;
        if (mode == 2) return fixed;
        for (int i = 15; i >= 0; i--) begin
            if (ar[i] && !ru[i/4] && !cu[i%4]) begin
                g[i] = 1'b1;
                ru[i/4] = 1'b1;
                cu[i%4] = 1'b1;
                if (mode == 1) return g;
            end
        end
        return g;
    endfunction

    always_comb agnt2 = model(mode2, areq2, fix2);
    always_comb agnt3 = model(mode3, areq3, fix3);

    c_wf_alloc_iter_ctrl #(.num_ports(4), .num_iters(2)) u_dut2 (
        .clk(clk), .reset(reset), .active(active), .start(start), .req(req),
        .busy(busy2), .alloc_req(areq2), .alloc_gnt(agnt2), .alloc_update(upd2),
        .gnt_valid(gv2), .gnt(gnt2), .ack(ack), .err(err2)
    );

    c_wf_alloc_iter_ctrl #(.num_ports(4), .num_iters(3)) u_dut3 (
        .clk(clk), .reset(reset), .active(active), .start(start), .req(req),
        .busy(busy3), .alloc_req(areq3), .alloc_gnt(agnt3), .alloc_update(upd3),
        .gnt_valid(gv3), .gnt(gnt3), .ack(ack), .err(err3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ack = 1'b1;
        while ((busy2 || busy3) && n < 10) begin
            cyc();
            n++;
        end
        ack = 1'b0;
        tests++;
        if (busy2 || busy3) begin
            fails++;
            $display("FAIL drain_timeout got busy2=%b busy3=%b exp 0 0", busy2, busy3);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; active = 1'b1; start = 1'b0; ack = 1'b0; req = '0;
        mode2 = 0; mode3 = 0; fix2 = '0; fix3 = '0;
        cyc(); cyc();
        tests++; if (busy2 !== 1'b0 || busy3 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b%b exp 00", busy2, busy3); end
        tests++; if (gv2 !== 1'b0 || gv3 !== 1'b0) begin fails++; $display("FAIL reset_gv got %b%b exp 00", gv2, gv3); end
        tests++; if (gnt2 !== 16'h0 || gnt3 !== 16'h0) begin fails++; $display("FAIL reset_gnt got %h %h exp 0", gnt2, gnt3); end
        tests++; if (areq2 !== 16'h0 || areq3 !== 16'h0) begin fails++; $display("FAIL reset_areq got %h %h exp 0", areq2, areq3); end
        tests++; if (upd2 !== 1'b0 || upd3 !== 1'b0) begin fails++; $display("FAIL reset_upd got %b%b exp 00", upd2, upd3); end
        tests++; if (err2 !== 1'b0 || err3 !== 1'b0) begin fails++; $display("FAIL reset_err got %b%b exp 00", err2, err3); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_diagonal();
        mode2 = 0; mode3 = 0;
        req = 16'h8421; start = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (areq3 !== 16'h8421) begin fails++; $display("FAIL diag_areq1 got %h exp 8421", areq3); end
        tests++; if (upd3 !== 1'b0 || busy3 !== 1'b1 || gv3 !== 1'b0) begin fails++; $display("FAIL diag_t1 got upd=%b busy=%b gv=%b exp 0 1 0", upd3, busy3, gv3); end
        cyc();
        tests++; if (areq3 !== 16'h0) begin fails++; $display("FAIL diag_areq2 got %h exp 0000", areq3); end
        tests++; if (upd3 !== 1'b1) begin fails++; $display("FAIL diag_upd got %b exp 1", upd3); end
        cyc();
        tests++; if (gv3 !== 1'b1 || gnt3 !== 16'h8421) begin fails++; $display("FAIL diag_gnt got gv=%b gnt=%h exp 1 8421", gv3, gnt3); end
        tests++; if (upd3 !== 1'b0) begin fails++; $display("FAIL diag_upd_after got %b exp 0", upd3); end
        cyc();
        tests++; if (gv3 !== 1'b1 || gnt3 !== 16'h8421) begin fails++; $display("FAIL diag_hold got gv=%b gnt=%h exp 1 8421", gv3, gnt3); end
        drain();
    endtask

    task automatic test_iter_limit();
        mode2 = 1; mode3 = 1;
        req = 16'hFFFF; start = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (areq2 !== 16'hFFFF || upd2 !== 1'b0) begin fails++; $display("FAIL lim_t1 got areq=%h upd=%b exp ffff 0", areq2, upd2); end
        cyc();
        tests++; if (areq2 !== 16'h0777) begin fails++; $display("FAIL lim_areq2 got %h exp 0777", areq2); end
        tests++; if (upd2 !== 1'b1) begin fails++; $display("FAIL lim_upd got %b exp 1", upd2); end
        tests++; if (busy3 !== 1'b1 || upd3 !== 1'b0) begin fails++; $display("FAIL lim3_t2 got busy=%b upd=%b exp 1 0", busy3, upd3); end
        cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h8400) begin fails++; $display("FAIL lim_gnt got gv=%b gnt=%h exp 1 8400", gv2, gnt2); end
        tests++; if (areq3 !== 16'h0033 || upd3 !== 1'b1) begin fails++; $display("FAIL lim3_t3 got areq=%h upd=%b exp 0033 1", areq3, upd3); end
        cyc();
        tests++; if (gv3 !== 1'b1 || gnt3 !== 16'h8420) begin fails++; $display("FAIL lim3_gnt got gv=%b gnt=%h exp 1 8420", gv3, gnt3); end
        drain();
    endtask

    task automatic test_empty();
        mode2 = 0; mode3 = 0;
        req = 16'h0000; start = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (busy2 !== 1'b1 || areq2 !== 16'h0 || upd2 !== 1'b0) begin fails++; $display("FAIL empty_t1 got busy=%b areq=%h upd=%b exp 1 0000 0", busy2, areq2, upd2); end
        cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h0 || upd2 !== 1'b0) begin fails++; $display("FAIL empty_t2 got gv=%b gnt=%h upd=%b exp 1 0000 0", gv2, gnt2, upd2); end
        tests++; if (gv3 !== 1'b1) begin fails++; $display("FAIL empty3_gv got %b exp 1", gv3); end
        drain();
    endtask

    task automatic test_reset_mid();
        mode2 = 0; mode3 = 0;
        req = 16'h8421; start = 1'b1;
        cyc(); start = 1'b0;
        reset = 1'b1;
        cyc(); reset = 1'b0;
        tests++; if (busy2 !== 1'b0 || gv2 !== 1'b0 || areq2 !== 16'h0 || upd2 !== 1'b0) begin fails++; $display("FAIL rmid_idle got busy=%b gv=%b areq=%h upd=%b exp 0 0 0000 0", busy2, gv2, areq2, upd2); end
        ack = 1'b1;
        cyc(); ack = 1'b0;
        tests++; if (busy2 !== 1'b0 || gv2 !== 1'b0 || gnt2 !== 16'h0) begin fails++; $display("FAIL rmid_ack got busy=%b gv=%b gnt=%h exp 0 0 0000", busy2, gv2, gnt2); end
        req = 16'h0421; start = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (areq2 !== 16'h0421) begin fails++; $display("FAIL rmid_areq got %h exp 0421", areq2); end
        cyc();
        tests++; if (upd2 !== 1'b1 || areq2 !== 16'h0) begin fails++; $display("FAIL rmid_t2 got upd=%b areq=%h exp 1 0000", upd2, areq2); end
        cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h0421) begin fails++; $display("FAIL rmid_gnt got gv=%b gnt=%h exp 1 0421", gv2, gnt2); end
        drain();
    endtask

    task automatic test_active();
        mode2 = 1; mode3 = 1;
        active = 1'b0; req = 16'h0001; start = 1'b1;
        cyc();
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL act_hold_idle got %b exp 0", busy2); end
        active = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (areq2 !== 16'h0001) begin fails++; $display("FAIL act_areq got %h exp 0001", areq2); end
        cyc();
        active = 1'b0;
        #1;
        tests++; if (upd2 !== 1'b0 || busy2 !== 1'b1 || areq2 !== 16'h0) begin fails++; $display("FAIL act_gated got upd=%b busy=%b areq=%h exp 0 1 0000", upd2, busy2, areq2); end
        cyc(); cyc();
        tests++; if (busy2 !== 1'b1 || gv2 !== 1'b0) begin fails++; $display("FAIL act_frozen got busy=%b gv=%b exp 1 0", busy2, gv2); end
        active = 1'b1;
        #1;
        tests++; if (upd2 !== 1'b1) begin fails++; $display("FAIL act_upd got %b exp 1", upd2); end
        cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h0001) begin fails++; $display("FAIL act_gnt got gv=%b gnt=%h exp 1 0001", gv2, gnt2); end
        drain();
    endtask

    task automatic test_back_to_back();
        mode2 = 0; mode3 = 0;
        req = 16'h8421; start = 1'b1; ack = 1'b1;
        cyc(); cyc(); cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h8421) begin fails++; $display("FAIL b2b_gnt got gv=%b gnt=%h exp 1 8421", gv2, gnt2); end
        cyc();
        tests++; if (busy2 !== 1'b0 || gv2 !== 1'b0 || gnt2 !== 16'h0) begin fails++; $display("FAIL b2b_bubble got busy=%b gv=%b gnt=%h exp 0 0 0000", busy2, gv2, gnt2); end
        cyc();
        tests++; if (busy2 !== 1'b1 || areq2 !== 16'h8421) begin fails++; $display("FAIL b2b_restart got busy=%b areq=%h exp 1 8421", busy2, areq2); end
        start = 1'b0;
        drain();
    endtask

    task automatic test_conflict();
        mode2 = 2; mode3 = 2; fix2 = 16'hC000; fix3 = 16'hC000;
        req = 16'hC000; start = 1'b1;
        cyc(); start = 1'b0;
        tests++; if (areq2 !== 16'hC000 || upd2 !== 1'b0) begin fails++; $display("FAIL cf_t1 got areq=%h upd=%b exp c000 0", areq2, upd2); end
        cyc();
`ifdef C_WF_ALLOC_ITER_CTRL_CHECK_EN
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'h0 || err2 !== 1'b1) begin fails++; $display("FAIL cf_chk got gv=%b gnt=%h err=%b exp 1 0000 1", gv2, gnt2, err2); end
        drain();
        tests++; if (err2 !== 1'b1 || err3 !== 1'b1) begin fails++; $display("FAIL cf_sticky got %b%b exp 11", err2, err3); end
        reset = 1'b1;
        cyc(); reset = 1'b0;
        tests++; if (err2 !== 1'b0 || err3 !== 1'b0) begin fails++; $display("FAIL cf_clear got %b%b exp 00", err2, err3); end
`else
        tests++; if (areq2 !== 16'h0 || upd2 !== 1'b1) begin fails++; $display("FAIL cf_t2 got areq=%h upd=%b exp 0000 1", areq2, upd2); end
        cyc();
        tests++; if (gv2 !== 1'b1 || gnt2 !== 16'hC000 || err2 !== 1'b0) begin fails++; $display("FAIL cf_nochk got gv=%b gnt=%h err=%b exp 1 c000 0", gv2, gnt2, err2); end
        drain();
`endif
        fix2 = '0; fix3 = '0; mode2 = 0; mode3 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_diagonal();
        test_iter_limit();
        test_empty();
        test_reset_mid();
        test_active();
        test_back_to_back();
        test_conflict();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
